// File: rtl/mux_n_to_1_reg_pkg.sv
// Shared constants and helpers for the registered N-to-1 handshake multiplexer.
package mux_n_to_1_reg_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Channel index reached by stepping 'step' places past 'base' (base < n, step <= n).
    function automatic int wrap_idx(input int base, input int step, input int n);
        int sum;
        sum = base + step;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/mux_n_to_1_reg_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr,
// scanning upward and wrapping from N-1 back to 0.
module rr_arbiter
    import mux_n_to_1_reg_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_valid
);

    logic [SELW-1:0] cand_idx [N];
    logic [N-1:0]    cand_req;

    // cand_idx[k] is the channel examined at priority position k (0 = highest).
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign cand_idx[gi] = SELW'(wrap_idx(int'(ptr), gi + 1, N));
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                gnt_idx   = cand_idx[k];
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_reg.sv
// N-to-1 multiplexer with a one-entry registered output and valid/ready on every
// channel; the source is chosen by an explicit select or by round-robin.
module mux_n_to_1_reg
    import mux_n_to_1_reg_pkg::*;
#(
    parameter  int WIDTH = 6,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] word [N];
    logic [SELW-1:0]  grant_idx;
    logic             grant_valid;
    logic             accept;
    logic             transfer;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_word
            assign word[gi] = in_data[gi*WIDTH +: WIDTH];
        end

        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] rr_ptr_reg;
            logic            unused_sel;

            assign unused_sel = ^sel;

            rr_arbiter #(.N(N)) u_arb (
                .req       (in_valid),
                .ptr       (rr_ptr_reg),
                .gnt_idx   (grant_idx),
                .gnt_valid (grant_valid)
            );

            // Priority only moves on a real transfer, so idle cycles keep fairness order.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_ptr_reg <= SELW'(N - 1);
                end else if (transfer) begin
                    rr_ptr_reg <= grant_idx;
                end
            end
        end else begin : g_sel
            assign grant_idx   = sel;
            assign grant_valid = (int'(sel) < N) && in_valid[sel];
        end
    endgenerate

    // The output register can take a word when empty or when it drains this cycle.
    assign accept   = ~out_valid | out_ready;
    assign transfer = ~rst & accept & grant_valid;

    always_comb begin
        in_ready = '0;
        if (transfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (accept) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= word[grant_idx];
                out_src   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
